// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer slice.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        PAR,
        DONE
    } state_t;

    localparam logic SEL_PARALLEL = 1'b0;
    localparam logic SEL_SERIAL   = 1'b1;

endpackage

// File: rtl/shift_reg_dp.sv
// NBITS shift register: parallel load or right shift with serial fill into the MSB.
module shift_reg_dp
    import shift_seq_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             en,
    input  logic             selecao,
    input  logic             ser_in,
    input  logic [NBITS-1:0] din,
    output logic [NBITS-1:0] dout
);

    logic [NBITS-1:0] dout_q;
    logic [NBITS-1:0] dout_d;

    always_comb begin
        dout_d = dout_q;
        if (en) begin
            if (selecao == SEL_PARALLEL) begin
                dout_d = din;
            end else begin
                dout_d = {ser_in, dout_q[NBITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load/shift sequencer: FSM, shift counter and parity around shift_reg_dp.
// Define SHIFT_PARITY_EN to append a PAR cycle that drives parity_out on ser_out.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int NBITS       = 4,
    parameter int NPAR_EN_BIT = 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] din,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] dout,
    output logic [3:0]       bit_cnt,
    output logic             parity_out
);

    localparam logic [3:0] LAST_CNT = 4'(NBITS - 1);

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       parity_q, parity_d;
    logic       dp_en;
    logic       dp_sel;
    logic       unused_npar_en;

    assign unused_npar_en = (NPAR_EN_BIT != 0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        dp_en     = 1'b0;
        dp_sel    = SEL_PARALLEL;
        busy      = 1'b1;
        done      = 1'b0;
        ser_out   = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = LOAD;
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                dp_en    = 1'b1;
                dp_sel   = SEL_PARALLEL;
                parity_d = ^din;
                state_d  = SHIFT;
            end
            SHIFT: begin
                dp_en     = 1'b1;
                dp_sel    = SEL_SERIAL;
                ser_out   = dout[0];
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == LAST_CNT) begin
`ifdef SHIFT_PARITY_EN
                    state_d = PAR;
`else
                    state_d = DONE;
`endif
                end
            end
            PAR: begin
`ifdef SHIFT_PARITY_EN
                ser_out = parity_q;
                state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
        end
    end

    assign bit_cnt    = bit_cnt_q;
    assign parity_out = parity_q;

    shift_reg_dp #(
        .NBITS(NBITS)
    ) u_dp (
        .clk_2   (clk_2),
        .reset   (reset),
        .en      (dp_en),
        .selecao (dp_sel),
        .ser_in  (ser_in),
        .din     (din),
        .dout    (dout)
    );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus randomized sequences.
module tb_shift_seq_ctrl;

    localparam int N = 4;
`ifdef SHIFT_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk_2 = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] din;
    logic         ser_in;
    logic         ser_out;
    logic         busy;
    logic         done;
    logic [N-1:0] dout;
    logic [3:0]   bit_cnt;
    logic         parity_out;

    int total = 0;
    int bad   = 0;

    shift_seq_ctrl #(
        .NBITS(N)
    ) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .start      (start),
        .din        (din),
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .bit_cnt    (bit_cnt),
        .parity_out (parity_out)
    );

    always #5 clk_2 = ~clk_2;

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected behaviour: ser_out replays d LSB first, the final word holds the
    // fill bits with the first fill bit ending in bit 0, done N+2 (or N+3) cycles after start.
    task automatic run_seq(input logic [N-1:0] d, input bit fixed_fill, input logic fill_val,
                           input bit hold_start);
        logic [N-1:0] exp_final;
        logic         s;
        logic         exp_par;
        exp_final = '0;
        exp_par   = ^d;
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        din   = d;
        step();
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_done", 32'(done), 32'd0);
        chk("load_ser_out", 32'(ser_out), 32'd0);
        chk("load_bit_cnt", 32'(bit_cnt), 32'd0);
        start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        for (int j = 0; j < N; j++) begin
            if (j == 0) chk("load_dout", 32'(dout), 32'(d));
            chk("shift_ser_out", 32'(ser_out), 32'(d[j]));
            chk("shift_bit_cnt", 32'(bit_cnt), 32'(j));
            chk("shift_busy", 32'(busy), 32'd1);
            chk("shift_done", 32'(done), 32'd0);
            s = fixed_fill ? fill_val : 1'($urandom_range(0, 1));
            ser_in       = s;
            exp_final[j] = s;
            din   = N'($urandom);
            start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        if (PAR_EN) begin
            chk("par_ser_out", 32'(ser_out), 32'(exp_par));
            chk("par_done", 32'(done), 32'd0);
            chk("par_busy", 32'(busy), 32'd1);
            step();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_dout", 32'(dout), 32'(exp_final));
        chk("done_bit_cnt", 32'(bit_cnt), 32'(N));
        chk("done_parity", 32'(parity_out), 32'(exp_par));
        chk("done_ser_out", 32'(ser_out), 32'd0);
        start = 1'b1;
        step();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        chk("post_dout_hold", 32'(dout), 32'(exp_final));
        chk("post_parity_hold", 32'(parity_out), 32'(exp_par));
        start = hold_start;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        din    = '0;
        ser_in = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        chk("rst_parity", 32'(parity_out), 32'd0);
        chk("rst_ser_out", 32'(ser_out), 32'd0);

        // Reset wins over start.
        start = 1'b1;
        din   = 4'b1111;
        step();
        chk("rst_prio_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        step();
        chk("idle_stay", 32'(busy), 32'd0);

        run_seq(4'b1011, 1'b1, 1'b0, 1'b0);
        step();
        chk("basic_no_extra", 32'(busy), 32'd0);

        run_seq(4'b0000, 1'b1, 1'b1, 1'b0);
        step();
        chk("fill_no_extra", 32'(busy), 32'd0);

        run_seq(4'b0111, 1'b1, 1'b0, 1'b0);
        step();

        // Start held high: back-to-back sequences with one IDLE cycle between.
        run_seq(4'b1001, 1'b0, 1'b0, 1'b1);
        run_seq(4'b0110, 1'b0, 1'b0, 1'b1);
        run_seq(4'b1110, 1'b0, 1'b0, 1'b0);
        step();
        chk("b2b_stop", 32'(busy), 32'd0);

        // Reset in the second SHIFT cycle aborts without a done pulse.
        start = 1'b1;
        din   = 4'b1101;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_in_shift", 32'(bit_cnt), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_bit_cnt", 32'(bit_cnt), 32'd0);
        chk("abort_parity", 32'(parity_out), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int k = 0; k < 2 * N; k++) begin
            step();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_stay_idle", 32'(busy), 32'd0);
        end

        for (int t = 0; t < 20; t++) begin
            run_seq(N'($urandom), 1'b0, 1'b0, 1'b0);
            step();
            chk("rand_idle", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
